regfile_dump_streamer: RTL and testbench

Debug reader for the CPU register file's flattened 32x32 debug bus. On a start pulse it snapshots the whole bus, then streams it out one register word per beat over a valid/ready handshake, index 0 first. It sits between the register file's debug output and the board-level debug/UART path, so writes during a dump never corrupt the streamed image.

---
 rtl/regfile_dump_streamer.sv | 142 ++++++++++++++
 tb/tb_regfile_dump_streamer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_streamer.sv
// rtl/regfile_dump_streamer.sv - snapshot the register-file debug bus and stream it one word per beat
// Optional feature macro: REG_DUMP_CHECKSUM_EN (appends an XOR checksum beat after the last register)
module regfile_dump_streamer #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 6
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] registers_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [IDX_W-1:0]               out_index,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int BEATS = NUM_REGS + 1;
`else
    localparam int BEATS = NUM_REGS;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] snap [NUM_REGS];
    logic [IDX_W-1:0]      next_idx;
    logic [DATA_WIDTH-1:0] next_word;
    logic                  capture;
    logic                  handshake;

    assign capture   = (state == IDLE) && start;
    assign handshake = out_valid && out_ready;
    assign next_idx  = out_index + IDX_W'(1);

    // Shadow copy of the whole bus taken on the start edge; contents are don't-care until then
    always_ff @(posedge clock) begin
        if (capture) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                snap[i] <= registers_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] bus_xor;
    logic [DATA_WIDTH-1:0] cksum;

    // XOR of every word on the live bus, so the checksum matches the captured image exactly
    always_comb begin
        bus_xor = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            bus_xor = bus_xor ^ registers_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Checksum is latched alongside the snapshot
    always_ff @(posedge clock) begin
        if (capture) begin
            cksum <= bus_xor;
        end
    end
`endif

    // Payload of the beat that follows the current one (checksum slot sits just past the last register)
    always_comb begin
        next_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (next_idx == IDX_W'(i)) begin
                next_word = snap[i];
            end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        if (next_idx == IDX_W'(NUM_REGS)) begin
            next_word = cksum;
        end
`endif
    end

    // Dump sequencer; all stream and status outputs are registered here
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= SEND;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_index <= '0;
                        out_data  <= registers_in[DATA_WIDTH-1:0];
                        out_last  <= (LAST_IDX == '0);
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (out_last) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_index <= next_idx;
                            out_data  <= next_word;
                            out_last  <= (next_idx == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// tb/tb_regfile_dump_streamer.sv - self-checking bench for regfile_dump_streamer
module tb_regfile_dump_streamer;
    localparam int NR = 32;
    localparam int DW = 32;
    localparam int IW = 6;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int NB = NR + 1;
`else
    localparam int NB = NR;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               out_ready = 1'b0;
    logic [NR*DW-1:0]   registers_in = '0;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [IW-1:0]      out_index;
    logic               out_last;
    logic               busy;
    logic               done;

    int checks = 0;
    int fails  = 0;

    logic [31:0] img [NR];
    logic [31:0] ed[$];
    int          ei[$];
    logic        el[$];
    logic [31:0] bd[$];
    int          bi[$];
    logic        bl[$];
    int          bc[$];
    int          done_cnt, done_cyc, idle_cyc, stall_bad, stall_cycles;
    bit          timed_out;

    regfile_dump_streamer #(.NUM_REGS(NR), .DATA_WIDTH(DW), .IDX_W(IW)) dut (
        .clock(clock), .reset(reset), .start(start), .registers_in(registers_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Reference: the stream is the image in index order, plus optional XOR word, last flag on final beat
    function automatic void build_expected();
        logic [31:0] x;
        x = '0;
        ed.delete(); ei.delete(); el.delete();
        for (int i = 0; i < NR; i++) begin
            ed.push_back(img[i]);
            ei.push_back(i);
            el.push_back(i == NB - 1);
            x = x ^ img[i];
        end
`ifdef REG_DUMP_CHECKSUM_EN
        ed.push_back(x);
        ei.push_back(NR);
        el.push_back(1'b1);
`endif
    endfunction

    task automatic load_image();
        for (int i = 0; i < NR; i++) registers_in[i*DW +: DW] = img[i];
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Drives out_ready per mode and records accepted beats and status timing (0=always ready, 1=random, 2=stall at index 5)
    task automatic collect(input int mode);
        int          stall_left = 3;
        logic [31:0] pd;
        logic [IW-1:0] pi;
        logic        pl;
        bit          prev_st = 0;
        bit          r;
        bd.delete(); bi.delete(); bl.delete(); bc.delete();
        done_cnt = 0; done_cyc = -1; idle_cyc = -1; stall_bad = 0; stall_cycles = 0; timed_out = 1;
        pd = '0; pi = '0; pl = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (prev_st && (out_valid !== 1'b1 || out_data !== pd || out_index !== pi || out_last !== pl))
                stall_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c > done_cyc && busy === 1'b0) begin
                idle_cyc = c;
                timed_out = 0;
                break;
            end
            case (mode)
                0: r = 1'b1;
                1: r = 1'($urandom_range(0, 1));
                default: begin
                    r = !(out_valid === 1'b1 && int'(out_index) == 5 && stall_left > 0);
                    if (!r) stall_left--;
                end
            endcase
            out_ready = r;
            if (out_valid === 1'b1 && r) begin
                bd.push_back(out_data); bi.push_back(int'(out_index));
                bl.push_back(out_last); bc.push_back(c);
            end
            if (out_valid === 1'b1 && !r) stall_cycles++;
            prev_st = (out_valid === 1'b1) && !r;
            pd = out_data; pi = out_index; pl = out_last;
            @(posedge clock); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b expected 0", out_last); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (out_index !== '0) begin fails++; $display("FAIL reset_index: got %0d expected 0", out_index); end
        checks++; if (out_data !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", out_data); end
        reset = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL idle_no_beat: got %b expected 0", out_valid); end
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < NR; i++) img[i] = 32'(i) * 32'h01010101;
        load_image(); build_expected();
        pulse_start();
        collect(0);
        checks++; if (timed_out) begin fails++; $display("FAIL t1_timeout: got timeout expected dump completion"); end
        checks++; if (bd.size() != NB) begin fails++; $display("FAIL t1_count: got %0d expected %0d", bd.size(), NB); end
        for (int k = 0; k < NB && k < bd.size(); k++) begin
            checks++;
            if (bd[k] !== ed[k] || bi[k] != ei[k] || bl[k] !== el[k] || bc[k] != k ||
                (k < NR && bd[k] !== 32'(k) * 32'h01010101)) begin
                fails++;
                $display("FAIL t1_beat%0d: got data=%h idx=%0d last=%b cyc=%0d expected data=%h idx=%0d last=%b cyc=%0d",
                         k, bd[k], bi[k], bl[k], bc[k], ed[k], ei[k], el[k], k);
            end
        end
        checks++; if (done_cyc != NB) begin fails++; $display("FAIL t1_done_cycle: got %0d expected %0d", done_cyc, NB); end
        checks++; if (done_cnt != 1) begin fails++; $display("FAIL t1_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (idle_cyc != NB + 1) begin fails++; $display("FAIL t1_busy_fall: got %0d expected %0d", idle_cyc, NB + 1); end
    endtask

    task automatic test_backpressure();
        pulse_start();
        collect(2);
        checks++; if (bd.size() != NB) begin fails++; $display("FAIL t2_count: got %0d expected %0d", bd.size(), NB); end
        for (int k = 0; k < NB && k < bd.size(); k++) begin
            checks++;
            if (bd[k] !== ed[k] || bi[k] != ei[k] || bl[k] !== el[k]) begin
                fails++;
                $display("FAIL t2_beat%0d: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                         k, bd[k], bi[k], bl[k], ed[k], ei[k], el[k]);
            end
        end
        checks++; if (stall_cycles != 3) begin fails++; $display("FAIL t2_stall_cycles: got %0d expected 3", stall_cycles); end
        checks++; if (stall_bad != 0) begin fails++; $display("FAIL t2_hold_stable: got %0d changes expected 0", stall_bad); end
        if (bc.size() > 6) begin
            checks++; if (bc[5] != 8 || bc[6] != 9) begin fails++; $display("FAIL t2_resume: got cyc5=%0d cyc6=%0d expected 8 9", bc[5], bc[6]); end
        end
    endtask

    task automatic test_capture_isolation();
        for (int i = 0; i < NR; i++) img[i] = $urandom;
        load_image(); build_expected();
        pulse_start();
        registers_in = '1;
        collect(0);
        checks++; if (bd.size() != NB) begin fails++; $display("FAIL t3_count: got %0d expected %0d", bd.size(), NB); end
        for (int k = 0; k < NB && k < bd.size(); k++) begin
            checks++;
            if (bd[k] !== ed[k] || bi[k] != ei[k]) begin
                fails++; $display("FAIL t3_beat%0d: got data=%h idx=%0d expected data=%h idx=%0d", k, bd[k], bi[k], ed[k], ei[k]);
            end
        end
        load_image();
    endtask

    task automatic test_start_held();
        int first_n;
        start = 1'b1;
        @(posedge clock); #1;
        collect(0);
        start = 1'b0;
        first_n = bd.size();
        checks++; if (first_n != NB) begin fails++; $display("FAIL t4_count: got %0d expected %0d", first_n, NB); end
        checks++; if (done_cnt != 1) begin fails++; $display("FAIL t4_done_pulses: got %0d expected 1", done_cnt); end
        repeat (3) begin
            @(posedge clock); #1;
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL t4_no_requeue: got valid=%b busy=%b expected 0 0", out_valid, busy); end
        end
        pulse_start();
        collect(0);
        checks++; if (bd.size() != NB) begin fails++; $display("FAIL t4_second_count: got %0d expected %0d", bd.size(), NB); end
        for (int k = 0; k < NB && k < bd.size(); k++) begin
            checks++;
            if (bd[k] !== ed[k] || bi[k] != ei[k] || bl[k] !== el[k]) begin
                fails++; $display("FAIL t4_beat%0d: got data=%h idx=%0d expected data=%h idx=%0d", k, bd[k], bi[k], ed[k], ei[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < NR; i++) img[i] = $urandom;
            load_image(); build_expected();
            pulse_start();
            collect(1);
            checks++; if (bd.size() != NB) begin fails++; $display("FAIL rnd%0d_count: got %0d expected %0d", t, bd.size(), NB); end
            for (int k = 0; k < NB && k < bd.size(); k++) begin
                checks++;
                if (bd[k] !== ed[k] || bi[k] != ei[k] || bl[k] !== el[k]) begin
                    fails++;
                    $display("FAIL rnd%0d_beat%0d: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                             t, k, bd[k], bi[k], bl[k], ed[k], ei[k], el[k]);
                end
            end
            checks++; if (stall_bad != 0) begin fails++; $display("FAIL rnd%0d_hold_stable: got %0d changes expected 0", t, stall_bad); end
            checks++; if (done_cnt != 1 || timed_out) begin fails++; $display("FAIL rnd%0d_done: got pulses=%0d timeout=%0d expected 1 0", t, done_cnt, timed_out); end
        end
    endtask

    task automatic test_async_reset();
        bit found = 0;
        pulse_start();
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid === 1'b1 && int'(out_index) == 10) begin
                found = 1;
                break;
            end
            @(posedge clock); #1;
        end
        checks++; if (!found) begin fails++; $display("FAIL t5_reach_idx10: got timeout expected index 10"); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t5_valid_async: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL t5_busy_async: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL t5_done_async: got %b expected 0", done); end
        out_ready = 1'b0;
        #10 reset = 1'b0;
        @(posedge clock); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL t5_quiet_c%0d: got valid=%b busy=%b expected 0 0", c, out_valid, busy); end
            @(posedge clock); #1;
        end
        out_ready = 1'b0;
    endtask

`ifdef REG_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < NR; i++) img[i] = '0;
        img[3] = 32'h12345678;
        img[7] = 32'h0000FFFF;
        load_image(); build_expected();
        pulse_start();
        collect(0);
        checks++; if (bd.size() != NR + 1) begin fails++; $display("FAIL t6_count: got %0d expected %0d", bd.size(), NR + 1); end
        if (bd.size() == NR + 1) begin
            checks++; if (bd[NR] !== 32'h1234A987 || bi[NR] != NR || bl[NR] !== 1'b1) begin
                fails++; $display("FAIL t6_cksum_beat: got data=%h idx=%0d last=%b expected data=1234a987 idx=%0d last=1", bd[NR], bi[NR], bl[NR], NR);
            end
            checks++; if (bl[NR-1] !== 1'b0) begin fails++; $display("FAIL t6_idx31_last: got %b expected 0", bl[NR-1]); end
            for (int k = 0; k < NR; k++) begin
                checks++; if (bd[k] !== ed[k] || bi[k] != k) begin fails++; $display("FAIL t6_beat%0d: got data=%h idx=%0d expected data=%h idx=%0d", k, bd[k], bi[k], ed[k], k); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_capture_isolation();
        test_start_held();
        test_random();
        test_async_reset();
`ifdef REG_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
